// File: rtl/tri_scheduler.sv
// Round-robin triangle scheduler: grants one source, streams its word MSB-first to the
// rasterizer, waits for DONE (or a timeout) and reports the triangle's valid-pixel count.
module tri_scheduler #(
   parameter int unsigned NREQ  = 2,
   parameter int unsigned TRI_W = 144,
   parameter int unsigned TO_W  = 20,
   parameter int unsigned GW    = 3
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [NREQ-1:0]         REQ,
   input  logic [NREQ*TRI_W-1:0]   TRI_IN,
   output logic [NREQ-1:0]         ACK,
   output logic                    RAST_D,
   input  logic                    RAST_VALID,
   input  logic                    RAST_DONE,
   output logic                    BUSY,
   output logic [GW-1:0]           GRANT_ID,
   output logic                    TRI_DONE,
   output logic [15:0]             PIX_COUNT,
   output logic                    TIMEOUT_ERR,
   input  logic                    CLR_ERR
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] FIN   = 2'd3;

   localparam int unsigned BCW = $clog2(TRI_W + 1);

   logic [1:0]       state_q, state_d;
   logic [TRI_W-1:0] sr_q, sr_d;
   logic [BCW-1:0]   bit_q, bit_d;
   logic [15:0]      pix_q, pix_d;
   logic [TO_W-1:0]  to_q, to_d;
   logic [GW-1:0]    ptr_q, ptr_d;
   logic [GW-1:0]    grant_q, grant_d;
   logic [NREQ-1:0]  ack_q, ack_d;
   logic             rast_d_q, rast_d_d;
   logic             tri_done_q, tri_done_d;
   logic [15:0]      pix_out_q, pix_out_d;
   logic             err_q, err_d;

   logic             found;
   logic [GW-1:0]    win;
   logic [GW-1:0]    ptr_nxt;
   logic [TRI_W-1:0] win_word;
   logic [TO_W-1:0]  to_inc;
   int unsigned      arb_idx;

   // Search upward from the pointer with wrap; first requester found wins.
   always_comb begin
      found   = 1'b0;
      win     = '0;
      arb_idx = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         arb_idx = 32'(ptr_q) + i;
         if (arb_idx >= NREQ) arb_idx = arb_idx - NREQ;
         if (!found && |(REQ & (NREQ'(1) << arb_idx))) begin
            found = 1'b1;
            win   = GW'(arb_idx);
         end
      end
   end

   assign win_word = TRI_W'(TRI_IN >> (32'(win) * TRI_W));
   assign ptr_nxt  = (32'(win) == NREQ - 1) ? '0 : win + GW'(1);
   assign to_inc   = to_q + TO_W'(1);

   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      bit_d      = bit_q;
      pix_d      = pix_q;
      to_d       = to_q;
      ptr_d      = ptr_q;
      grant_d    = grant_q;
      ack_d      = '0;
      tri_done_d = 1'b0;
      pix_out_d  = pix_out_q;
      err_d      = err_q;

      if (CLR_ERR) err_d = 1'b0;
      if (state_q != IDLE && RAST_VALID && pix_q != 16'hFFFF) pix_d = pix_q + 16'd1;

      case (state_q)
         IDLE: begin
            if (found) begin
               sr_d    = win_word;
               grant_d = win;
               ptr_d   = ptr_nxt;
               bit_d   = '0;
               pix_d   = '0;
               ack_d   = NREQ'(1) << win;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sr_d  = sr_q << 1;
            bit_d = bit_q + BCW'(1);
            if (bit_q == BCW'(TRI_W - 1)) begin
               state_d = WAIT;
               to_d    = '0;
            end
         end
         WAIT: begin
            if (RAST_DONE) begin
               state_d = FIN;
            end else begin
               to_d = to_inc;
               // A timeout set overrides a same-cycle CLR_ERR.
               if (to_inc == '1) begin
                  err_d   = 1'b1;
                  state_d = FIN;
               end
            end
         end
         FIN: begin
            tri_done_d = 1'b1;
            pix_out_d  = pix_d;
            state_d    = IDLE;
         end
      endcase

      rast_d_d = (state_d == SHIFT) ? sr_d[TRI_W-1] : 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q    <= IDLE;
         sr_q       <= '0;
         bit_q      <= '0;
         pix_q      <= '0;
         to_q       <= '0;
         ptr_q      <= '0;
         grant_q    <= '0;
         ack_q      <= '0;
         rast_d_q   <= 1'b0;
         tri_done_q <= 1'b0;
         pix_out_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         bit_q      <= bit_d;
         pix_q      <= pix_d;
         to_q       <= to_d;
         ptr_q      <= ptr_d;
         grant_q    <= grant_d;
         ack_q      <= ack_d;
         rast_d_q   <= rast_d_d;
         tri_done_q <= tri_done_d;
         pix_out_q  <= pix_out_d;
         err_q      <= err_d;
      end
   end

   assign ACK         = ack_q;
   assign RAST_D      = rast_d_q;
   assign BUSY        = (state_q != IDLE);
   assign GRANT_ID    = grant_q;
   assign TRI_DONE    = tri_done_q;
   assign PIX_COUNT   = pix_out_q;
   assign TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_tri_scheduler.sv
// Bench for tri_scheduler: directed vector table, timeout and reset sequences, then
// randomized traffic checked against a transaction-level round-robin model.
module tb_tri_scheduler;

   localparam int NREQ  = 2;
   localparam int TRI_W = 144;
   localparam int GW    = 3;

   logic                  CLK;
   logic                  RST, rst_t;
   logic [NREQ-1:0]       REQ, req_t;
   logic [NREQ*TRI_W-1:0] TRI_IN;
   logic                  RAST_VALID;
   logic                  RAST_DONE, done_t;
   logic                  CLR_ERR, clr_t;
   logic [NREQ-1:0]       ack, ack_t;
   logic                  rast_d, rast_d_t;
   logic                  busy, busy_t;
   logic [GW-1:0]         grant_id, grant_t;
   logic                  tri_done, tri_done_t;
   logic [15:0]           pix_count, pix_t;
   logic                  terr, terr_t;

   int checks = 0;
   int errors = 0;
   int rr_ptr = 0;

   tri_scheduler #(.NREQ(NREQ), .TRI_W(TRI_W), .TO_W(20), .GW(GW)) u_dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .TRI_IN(TRI_IN), .ACK(ack), .RAST_D(rast_d),
      .RAST_VALID(RAST_VALID), .RAST_DONE(RAST_DONE), .BUSY(busy), .GRANT_ID(grant_id),
      .TRI_DONE(tri_done), .PIX_COUNT(pix_count), .TIMEOUT_ERR(terr), .CLR_ERR(CLR_ERR)
   );

   // Short-timeout instance: 15 WAIT cycles before the hang is flagged.
   tri_scheduler #(.NREQ(NREQ), .TRI_W(TRI_W), .TO_W(4), .GW(GW)) u_dut_to (
      .CLK(CLK), .RST(rst_t), .REQ(req_t), .TRI_IN(TRI_IN), .ACK(ack_t), .RAST_D(rast_d_t),
      .RAST_VALID(RAST_VALID), .RAST_DONE(done_t), .BUSY(busy_t), .GRANT_ID(grant_t),
      .TRI_DONE(tri_done_t), .PIX_COUNT(pix_t), .TIMEOUT_ERR(terr_t), .CLR_ERR(clr_t)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [NREQ-1:0] req;
      int              exp_g;
      int              delay;
      int              vmode;   // 0 no pixels, 1 last nv WAIT cycles, 2 random
      int              nv;
      bit              stray;
      int              exp_pix;
   } vec_t;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [TRI_W-1:0] act,
                      input logic [TRI_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [TRI_W-1:0] rand_word();
      logic [159:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return r[TRI_W-1:0];
   endfunction

   // Starts in an IDLE cycle; ends in the IDLE cycle that shows TRI_DONE.
   task automatic serve(input logic [NREQ-1:0] req, input int exp_g, input int delay,
                        input int vmode, input int nv, input bit stray, input int exp_pix);
      logic [TRI_W-1:0] got, want;
      logic [NREQ-1:0]  exp_ack;
      int               cnt;
      bit               bad, v;
      want    = TRI_IN[exp_g*TRI_W +: TRI_W];
      exp_ack = '0;
      exp_ack[exp_g] = 1'b1;
      cnt = 0;
      bad = 0;
      REQ        = req;
      RAST_DONE  = stray || (vmode == 2 && $urandom_range(0, 3) == 0);
      RAST_VALID = (vmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      chk("ack", ack, exp_ack);
      chk("grant_id", grant_id, exp_g);
      chk("busy_shift", busy, 1);
      chk("tri_done_one_cycle", tri_done, 0);
      REQ[exp_g] = 1'b0;
      rr_ptr = (exp_g + 1) % NREQ;
      for (int k = 0; k < TRI_W; k++) begin
         got[TRI_W-1-k] = rast_d;
         if (k > 0 && ack != 0) bad = 1;
         if (tri_done) bad = 1;
         v = (vmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
         RAST_VALID = v;
         cnt += int'(v);
         RAST_DONE = (stray && k == 60) || (vmode == 2 && $urandom_range(0, 31) == 0);
         step();
      end
      chk("rast_d_wait", rast_d, 0);
      for (int j = 0; j <= delay; j++) begin
         if (ack != 0 || tri_done || !busy) bad = 1;
         RAST_DONE = (j == delay);
         if (vmode == 1) v = (j >= delay + 1 - nv);
         else if (vmode == 2) v = 1'($urandom_range(0, 1));
         else v = 1'b0;
         RAST_VALID = v;
         cnt += int'(v);
         step();
      end
      RAST_DONE = 1'b0;
      chk("busy_fin", busy, 1);
      chk("tri_done_fin", tri_done, 0);
      v = (vmode == 2) ? 1'($urandom_range(0, 1)) : (vmode == 1 && nv > delay + 1);
      RAST_VALID = v;
      cnt += int'(v);
      step();
      RAST_VALID = 1'b0;
      REQ = '0;
      chk("serial_word", got, want);
      chk("quiet_while_busy", bad, 0);
      chk("tri_done", tri_done, 1);
      chk("pix_count", pix_count, (exp_pix < 0) ? cnt : exp_pix);
      chk("busy_idle", busy, 0);
   endtask

   vec_t tbl[8];

   initial begin
      logic [NREQ-1:0] pend, exp_ack;
      logic [TRI_W-1:0] w;
      int g;

      tbl[0] = '{req: 2'b01, exp_g: 0, delay: 10, vmode: 0, nv: 0,  stray: 0, exp_pix: 0};
      tbl[1] = '{req: 2'b10, exp_g: 1, delay: 3,  vmode: 0, nv: 0,  stray: 0, exp_pix: 0};
      tbl[2] = '{req: 2'b11, exp_g: 0, delay: 0,  vmode: 0, nv: 0,  stray: 0, exp_pix: 0};
      tbl[3] = '{req: 2'b11, exp_g: 1, delay: 1,  vmode: 0, nv: 0,  stray: 0, exp_pix: 0};
      tbl[4] = '{req: 2'b11, exp_g: 0, delay: 2,  vmode: 0, nv: 0,  stray: 0, exp_pix: 0};
      tbl[5] = '{req: 2'b11, exp_g: 1, delay: 0,  vmode: 0, nv: 0,  stray: 0, exp_pix: 0};
      tbl[6] = '{req: 2'b11, exp_g: 0, delay: 5,  vmode: 0, nv: 0,  stray: 1, exp_pix: 0};
      tbl[7] = '{req: 2'b01, exp_g: 0, delay: 36, vmode: 1, nv: 37, stray: 0, exp_pix: 37};

      RST = 1'b0; rst_t = 1'b0;
      REQ = '0; req_t = '0;
      RAST_VALID = 1'b0; RAST_DONE = 1'b0; done_t = 1'b0;
      CLR_ERR = 1'b0; clr_t = 1'b0;
      TRI_IN = {rand_word(), rand_word()};
      step();
      step();
      chk("rst_ack", ack, 0);
      chk("rst_rast_d", rast_d, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_tri_done", tri_done, 0);
      chk("rst_pix_count", pix_count, 0);
      chk("rst_timeout_err", terr, 0);
      RST = 1'b1; rst_t = 1'b1;

      // Timeout on the short-timeout instance.
      req_t = 2'b01;
      step();
      chk("to_ack", ack_t, 2'b01);
      chk("to_first_bit", rast_d_t, TRI_IN[TRI_W-1]);
      req_t = '0;
      for (int k = 0; k < TRI_W + 14; k++) step();
      chk("to_err_before", terr_t, 0);
      chk("to_busy_before", busy_t, 1);
      step();
      chk("to_err_set", terr_t, 1);
      chk("to_fin_no_done", tri_done_t, 0);
      step();
      chk("to_tri_done", tri_done_t, 1);
      chk("to_busy_idle", busy_t, 0);
      chk("to_pix", pix_t, 0);
      req_t = 2'b10;
      step();
      chk("to_next_ack", ack_t, 2'b10);
      chk("to_next_grant", grant_t, 1);
      chk("to_err_sticky", terr_t, 1);
      req_t = '0;
      clr_t = 1'b1;
      step();
      chk("to_err_clr", terr_t, 0);
      for (int k = 0; k < TRI_W - 1 + 15; k++) step();
      chk("to_set_wins", terr_t, 1);
      step();
      chk("to_clr_after", terr_t, 0);
      chk("to_tri_done2", tri_done_t, 1);
      clr_t = 1'b0;

      // Directed table on the main instance.
      for (int i = 0; i < 8; i++) begin
         TRI_IN = {rand_word(), rand_word()};
         if (i == 0) begin
            w = '0;
            w[TRI_W-1] = 1'b1;
            w[0] = 1'b1;
            TRI_IN[TRI_W-1:0] = w;
         end
         serve(tbl[i].req, tbl[i].exp_g, tbl[i].delay, tbl[i].vmode, tbl[i].nv,
               tbl[i].stray, tbl[i].exp_pix);
      end

      // Pixels in IDLE must not disturb the reported count.
      for (int k = 0; k < 5; k++) begin
         RAST_VALID = 1'b1;
         step();
      end
      RAST_VALID = 1'b0;
      chk("idle_pix_hold", pix_count, tbl[7].exp_pix);
      chk("idle_no_done", tri_done, 0);

      // Reset in the middle of shifting; pointer would otherwise favour source 1.
      REQ = 2'b01;
      step();
      chk("mid_ack", ack, 2'b01);
      REQ = '0;
      RAST_VALID = 1'b1;
      for (int k = 0; k < 50; k++) step();
      RST = 1'b0;
      step();
      RST = 1'b1;
      RAST_VALID = 1'b0;
      chk("mid_busy", busy, 0);
      chk("mid_rast_d", rast_d, 0);
      chk("mid_pix", pix_count, 0);
      chk("mid_tri_done", tri_done, 0);
      step();
      chk("mid_still_idle", busy, 0);
      chk("mid_no_done", tri_done, 0);
      rr_ptr = 0;
      TRI_IN = {rand_word(), rand_word()};
      serve(2'b11, 0, 4, 0, 0, 0, 0);
      serve(2'b10, 1, 2, 0, 0, 0, 0);

      // Random traffic against the round-robin model.
      pend = '0;
      for (int t = 0; t < 20; t++) begin
         for (int s = 0; s < NREQ; s++) begin
            if (!pend[s] && $urandom_range(0, 1) == 1) begin
               pend[s] = 1'b1;
               TRI_IN[s*TRI_W +: TRI_W] = rand_word();
            end
         end
         if (pend == '0) begin
            pend[0] = 1'b1;
            TRI_IN[TRI_W-1:0] = rand_word();
         end
         g = -1;
         for (int i = 0; i < NREQ; i++) begin
            if (g < 0 && pend[(rr_ptr + i) % NREQ]) g = (rr_ptr + i) % NREQ;
         end
         serve(pend, g, $urandom_range(0, 20), 2, 0, 0, -1);
         pend[g] = 1'b0;
      end

      exp_ack = '0;
      step();
      chk("final_ack", ack, exp_ack);
      chk("final_err", terr, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
